// File: rtl/iob_cpu_bus_router_pkg.sv
// Shared types and helpers for the CPU bus router.
// Holds the FSM encoding, error data default and flat-bus field offsets.
package iob_cpu_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    // Low bit of field idx in a flattened bus of w-bit fields.
    function automatic int unsigned fld_lo(
        input int unsigned idx,
        input int unsigned w
    );
        return idx * w;
    endfunction

endpackage

// File: rtl/iob_bus_watchdog.sv
// Per-transaction wait counter for the CPU bus router.
// Expires on the last allowed wait cycle so the timeout lands on the final count.
module iob_bus_watchdog #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/iob_cpu_bus_router.sv
// Address-decoded router from a native CPU port to N native slave ports.
// Single outstanding request, boot remap, watchdog and sticky error report.
module iob_cpu_bus_router
    import iob_cpu_bus_router_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          N_SLAVES   = 4,
    parameter int          SEL_W      = 2,
    parameter int          BOOT_SLAVE = 0,
    parameter int          TIMEOUT_W  = 8,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         boot,
    input  logic                         err_clr,
    input  logic                         cpu_valid,
    input  logic                         cpu_instr,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic [DATA_W/8-1:0]          cpu_wstrb,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [N_SLAVES*ADDR_W-1:0]   s_addr,
    output logic [N_SLAVES*DATA_W-1:0]   s_wdata,
    output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic                         bus_err,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);
    localparam logic [ADDR_W-1:0] OFFS_MASK =
        {{SEL_W{1'b0}}, {(ADDR_W-SEL_W){1'b1}}};

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [SEL_W-1:0]  dec_sel;
    logic              dec_err;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              wd_expired;
    logic              err_set;
    logic [ADDR_W-1:0] err_src;

    always_comb begin
        dec_sel = cpu_addr[ADDR_W-1 -: SEL_W];
        if (boot && cpu_instr) begin
            dec_sel = SEL_W'(BOOT_SLAVE);
        end
        dec_err = (int'(dec_sel) >= N_SLAVES);
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (req_q.sel == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    iob_bus_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdog (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (state_q == ST_RESP),
        .en      (state_q == ST_REQ),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_set = 1'b0;
        err_src = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_valid && dec_err) begin
                    state_d = ST_RESP;
                    rdata_d = ERR_RDATA;
                    err_set = 1'b1;
                    err_src = cpu_addr;
                end else if (cpu_valid) begin
                    state_d = ST_REQ;
                    req_d   = '{dec_sel, cpu_addr, cpu_wdata, cpu_wstrb};
                end
            end
            ST_REQ: begin
                // A ready arriving on the last wait cycle still completes normally.
                if (sel_ready) begin
                    state_d = ST_RESP;
                    rdata_d = sel_rdata;
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    rdata_d = ERR_RDATA;
                    err_set = 1'b1;
                    err_src = req_q.addr;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A new error in the clearing cycle becomes the new first error.
    always_comb begin
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            bus_err_d  = 1'b0;
            err_addr_d = '0;
        end
        if (err_set) begin
            bus_err_d = 1'b1;
            if (!bus_err_q || err_clr) begin
                err_addr_d = err_src;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_slv
        assign s_valid[g] = (state_q == ST_REQ) && (req_q.sel == SEL_W'(g));
        assign s_addr[fld_lo(g, ADDR_W) +: ADDR_W]  = req_q.addr & OFFS_MASK;
        assign s_wdata[fld_lo(g, DATA_W) +: DATA_W] = req_q.wdata;
        assign s_wstrb[fld_lo(g, STRB_W) +: STRB_W] = req_q.wstrb;
    end

    assign cpu_ready = (state_q == ST_RESP);
    assign cpu_rdata = rdata_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_iob_cpu_bus_router.sv
// Directed bench for iob_cpu_bus_router with a cycle-timeline reference model.
// Three slaves, 4-bit watchdog, so the top select code is a decode error.
module tb_iob_cpu_bus_router;

    localparam int NS = 3;
    localparam int TW = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        boot = 1'b0;
    logic        err_clr = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_instr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [2:0]  s_valid;
    logic [95:0] s_addr;
    logic [95:0] s_wdata;
    logic [11:0] s_wstrb;
    logic [95:0] s_rdata;
    logic [2:0]  s_ready = '0;
    logic        bus_err;
    logic [31:0] err_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          dly [NS];
    logic [31:0] sdat [NS];
    logic [2:0]  stray = '0;

    int          e_first = -1, e_last = -2, e_rdy = -1, e_sel = 0;
    logic        e_err_ev = 1'b0;
    logic [31:0] e_rdata = '0, e_addr_out = '0, e_wdata = '0, e_err_src = '0;
    logic [3:0]  e_wstrb = '0;
    int          clr_cyc = -10;
    logic        m_err = 1'b0;
    logic [31:0] m_eaddr = '0;

    logic [2:0]  seen_sv;
    logic [31:0] seen_addr;
    int          sv_cycles, sv_first, rdy_cnt, rdy_cyc;

    iob_cpu_bus_router #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .N_SLAVES   (NS),
        .SEL_W      (2),
        .BOOT_SLAVE (0),
        .TIMEOUT_W  (TW),
        .ERR_DATA   (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .boot      (boot),
        .err_clr   (err_clr),
        .cpu_valid (cpu_valid),
        .cpu_instr (cpu_instr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s_rdata = {sdat[2], sdat[1], sdat[0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_seen();
        seen_sv = '0;
        seen_addr = '0;
        sv_cycles = 0;
        sv_first = -1;
        rdy_cnt = 0;
        rdy_cyc = -1;
    endtask

    // Slave model: ready dly cycles after s_valid rises; dly<0 never answers.
    initial begin
        int cnt [NS];
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (s_valid[i]) cnt[i]++;
                else cnt[i] = 0;
                s_ready[i] = (dly[i] >= 0 && cnt[i] == dly[i] + 1) || stray[i];
            end
        end
    end

    // Per-cycle comparison against the expected timeline.
    initial begin
        logic [2:0] ev;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_err = 1'b0;
                m_eaddr = '0;
            end else begin
                if (cyc == clr_cyc + 1) begin
                    m_err = 1'b0;
                    m_eaddr = '0;
                end
                if (cyc == e_rdy && e_err_ev) begin
                    if (!m_err) m_eaddr = e_err_src;
                    m_err = 1'b1;
                end
            end
            ev = (cyc >= e_first && cyc <= e_last) ? 3'(1 << e_sel) : 3'b000;
            chk("s_valid", 64'(s_valid), 64'(ev));
            if (s_valid != 0) begin
                seen_sv = s_valid;
                sv_cycles++;
                if (sv_cycles == 1) sv_first = cyc;
                for (int i = 0; i < NS; i++)
                    if (s_valid[i]) seen_addr = s_addr[i*32 +: 32];
            end
            if (ev != 0) begin
                chk("s_addr", 64'(s_addr[e_sel*32 +: 32]), 64'(e_addr_out));
                chk("s_wdata", 64'(s_wdata[e_sel*32 +: 32]), 64'(e_wdata));
                chk("s_wstrb", 64'(s_wstrb[e_sel*4 +: 4]), 64'(e_wstrb));
            end
            chk("cpu_ready", 64'(cpu_ready), 64'(cyc == e_rdy));
            if (cpu_ready) begin
                rdy_cnt++;
                rdy_cyc = cyc;
            end
            if (cyc == e_rdy) chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rdata));
            chk("bus_err", 64'(bus_err), 64'(m_err));
            chk("err_addr", 64'(err_addr), 64'(m_eaddr));
        end
    end

    task automatic set_req(input logic [31:0] a, input logic ins,
                           input logic [31:0] wd, input logic [3:0] ws);
        cpu_valid = 1'b1;
        cpu_instr = ins;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
    endtask

    task automatic xact(input logic [31:0] a, input logic ins, input logic [31:0] wd,
                        input logic [3:0] ws, input logic clr);
        int sel;
        int c0;
        int n;
        sel = (boot && ins) ? 0 : int'(a[31:30]);
        c0 = cyc;
        set_req(a, ins, wd, ws);
        if (clr) begin
            err_clr = 1'b1;
            clr_cyc = c0;
        end
        if (sel >= NS) begin
            e_first = -1; e_last = -2; e_rdy = c0 + 1;
            e_rdata = 32'hDEADBEEF; e_err_ev = 1'b1; e_err_src = a;
        end else begin
            e_sel = sel; e_first = c0 + 1;
            e_addr_out = a & 32'h3FFF_FFFF; e_wdata = wd; e_wstrb = ws;
            if (dly[sel] < 0 || dly[sel] >= (1 << TW) - 1) begin
                e_last = c0 + (1 << TW) - 1; e_rdy = e_last + 1;
                e_rdata = 32'hDEADBEEF; e_err_ev = 1'b1; e_err_src = a;
            end else begin
                e_last = c0 + 1 + dly[sel]; e_rdy = e_last + 1;
                e_rdata = sdat[sel]; e_err_ev = 1'b0;
            end
        end
        n = 0;
        while (!cpu_ready && n < 40) begin
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            n++;
        end
        if (!cpu_ready) begin
            checks++;
            failures++;
            $display("FAIL xact_wait: no cpu_ready for addr %0h within 40 cycles", a);
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        cpu_instr = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        clr_cyc = cyc;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_bus_err", 64'(bus_err), 64'd0);
        chk("clr_err_addr", 64'(err_addr), 64'd0);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < NS; i++) dly[i] = 0;
        sdat[0] = 32'hA0A0_0001;
        sdat[1] = 32'hB1B1_1111;
        sdat[2] = 32'h1234_5678;
        clear_seen();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_s_addr_nz", 64'(s_addr != '0), 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        dly[2] = 3;
        clear_seen();
        xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("t1_sv", 64'(seen_sv), 64'(3'b100));
        chk("t1_saddr", 64'(seen_addr), 64'h10);
        chk("t1_rdata", 64'(cpu_rdata), 64'h1234_5678);
        chk("t1_ready_cnt", 64'(rdy_cnt), 64'd1);
        chk("t1_latency", 64'(rdy_cyc - sv_first), 64'd4);

        dly[0] = 1;
        dly[1] = 0;
        boot = 1'b1;
        clear_seen();
        xact(32'h4000_0000, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("boot_fetch_sv", 64'(seen_sv), 64'(3'b001));
        chk("boot_fetch_rdata", 64'(cpu_rdata), 64'hA0A0_0001);
        boot = 1'b0;
        clear_seen();
        xact(32'h4000_0000, 1'b1, 32'h0, 4'h0, 1'b0);
        chk("noboot_fetch_sv", 64'(seen_sv), 64'(3'b010));
        boot = 1'b1;
        clear_seen();
        xact(32'h4000_0004, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("boot_data_sv", 64'(seen_sv), 64'(3'b010));
        chk("boot_data_saddr", 64'(seen_addr), 64'h4);
        boot = 1'b0;

        clear_seen();
        xact(32'hC000_0000, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("dec_sv", 64'(seen_sv), 64'd0);
        chk("dec_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("dec_bus_err", 64'(bus_err), 64'd1);
        chk("dec_err_addr", 64'(err_addr), 64'hC000_0000);
        do_clr();

        dly[1] = -1;
        clear_seen();
        xact(32'h4000_0100, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("to_sv_cycles", 64'(sv_cycles), 64'd15);
        chk("to_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("to_bus_err", 64'(bus_err), 64'd1);
        chk("to_err_addr", 64'(err_addr), 64'h4000_0100);
        xact(32'hC000_0040, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("second_err_addr", 64'(err_addr), 64'h4000_0100);
        do_clr();

        clear_seen();
        set_req(32'h4000_0020, 1'b0, 32'h5555_AAAA, 4'hF);
        c0 = cyc;
        e_sel = 1; e_first = c0 + 1; e_last = c0 + 1000; e_rdy = -1;
        e_addr_out = 32'h20; e_wdata = 32'h5555_AAAA; e_wstrb = 4'hF; e_err_ev = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_sv", 64'(s_valid), 64'(3'b010));
        resetn = 1'b0;
        e_first = -1;
        e_last = -2;
        #1;
        chk("mid_rst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("mid_rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("mid_rst_s_valid", 64'(s_valid), 64'd0);
        chk("mid_rst_s_addr_nz", 64'(s_addr != '0), 64'd0);
        chk("mid_rst_s_wdata_nz", 64'(s_wdata != '0), 64'd0);
        chk("mid_rst_s_wstrb_nz", 64'(s_wstrb != '0), 64'd0);
        cpu_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_no_ready", 64'(rdy_cnt), 64'd0);
        dly[1] = 1;
        clear_seen();
        xact(32'h4000_0024, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("post_rst_ready_cnt", 64'(rdy_cnt), 64'd1);
        chk("post_rst_rdata", 64'(cpu_rdata), 64'hB1B1_1111);

        dly[1] = 2;
        dly[2] = 0;
        clear_seen();
        xact(32'h4000_0008, 1'b0, 32'hCAFE_F00D, 4'b0011, 1'b0);
        chk("wr_sv", 64'(seen_sv), 64'(3'b010));
        chk("wr_saddr", 64'(seen_addr), 64'h8);
        chk("wr_rdata", 64'(cpu_rdata), 64'hB1B1_1111);
        chk("wr_ready_cnt", 64'(rdy_cnt), 64'd1);
        clear_seen();
        xact(32'h8000_0044, 1'b0, 32'h0, 4'h0, 1'b0);
        chk("b2b_rd_sv", 64'(seen_sv), 64'(3'b100));
        chk("b2b_rd_saddr", 64'(seen_addr), 64'h44);
        chk("b2b_rd_rdata", 64'(cpu_rdata), 64'h1234_5678);
        chk("b2b_rd_ready_cnt", 64'(rdy_cnt), 64'd1);

        dly[0] = 2;
        stray = 3'b100;
        clear_seen();
        xact(32'h0000_0030, 1'b0, 32'h0, 4'h0, 1'b0);
        stray = 3'b000;
        chk("stray_sv", 64'(seen_sv), 64'(3'b001));
        chk("stray_latency", 64'(rdy_cyc - sv_first), 64'd3);
        chk("stray_rdata", 64'(cpu_rdata), 64'hA0A0_0001);

        xact(32'hC000_0080, 1'b0, 32'h0, 4'h0, 1'b1);
        chk("errwin_bus_err", 64'(bus_err), 64'd1);
        chk("errwin_err_addr", 64'(err_addr), 64'hC000_0080);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: bench did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
